// File: rtl/last_word_console_pkg.sv
// last_word_console_pkg: mailbox word field positions, TX state encodings and word decode helper (rev 1.0)
`default_nettype none

package last_word_console_pkg;

  localparam int HALT_BIT    = 31;
  localparam int TOGGLE_BIT  = 30;
  localparam int PAYLOAD_MSB = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic                   halt;
    logic                   toggle;
    logic [PAYLOAD_MSB:0]   payload;
  } mbox_word_t;

  // Bits [29:8] of the mailbox word carry nothing for this consumer.
  function automatic mbox_word_t decode_word(input logic [31:0] w);
    mbox_word_t d;
    d.halt    = w[HALT_BIT];
    d.toggle  = w[TOGGLE_BIT];
    d.payload = w[PAYLOAD_MSB:0];
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/last_word_console_if.sv
// last_word_console_if: mailbox input and console/status outputs of last_word_console (rev 1.0)
`default_nettype none

interface last_word_console_if;
  logic [31:0] iwLastData;
  logic        owTx;
  logic        owHalt;
  logic [7:0]  owExitCode;
  logic        owOverflow;
  logic        owBusy;

  modport master (
    output iwLastData,
    input  owTx, owHalt, owExitCode, owOverflow, owBusy
  );

  modport slave (
    input  iwLastData,
    output owTx, owHalt, owExitCode, owOverflow, owBusy
  );
endinterface

`default_nettype wire

// File: rtl/last_word_console_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; pushes when full and pops when empty are ignored (rev 1.0)
`default_nettype none

module sync_fifo #(
  parameter int pWidth = 8,
  parameter int pDepth = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [pWidth-1:0] data_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [pWidth-1:0] data_o,
  output logic              empty_o
);

  localparam int            AW      = $clog2(pDepth);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(pDepth);

  logic [AW:0]       wr_q, rd_q;
  logic [pWidth-1:0] mem_q [pDepth];
  logic              do_push, do_pop;

  assign full_o  = (wr_q - rd_q) == C_DEPTH;
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/last_word_console.sv
// last_word_console: decodes toggled mailbox words into halt status or console characters sent as 8N1 UART (rev 1.0)
`default_nettype none

module last_word_console
  import last_word_console_pkg::*;
#(
  parameter logic [15:0] pClkDiv    = 16'd434,
  parameter int          pFifoDepth = 8
) (
  input  logic                iwClk,
  input  logic                iwnRst,
  last_word_console_if.slave  bus
);

  localparam logic [15:0] C_RELOAD = pClkDiv - 16'd1;

  mbox_word_t word;
  logic       evt, accept, push, drop, pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_data;

  logic       toggle_q, halt_q, ovf_q;
  logic [7:0] exit_q;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  assign word   = decode_word(bus.iwLastData);
  assign evt    = (word.toggle != toggle_q);
  assign accept = evt && !halt_q;
  // Fullness is judged before the edge, so a same-edge pop never rescues a push.
  assign push   = accept && !word.halt && !fifo_full;
  assign drop   = accept && !word.halt && fifo_full;

  always_ff @(posedge iwClk) begin
    if (!iwnRst) begin
      toggle_q <= 1'b0;
      halt_q   <= 1'b0;
      exit_q   <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (evt)                 toggle_q <= word.toggle;
      if (accept && word.halt) begin
        halt_q <= 1'b1;
        exit_q <= word.payload;
      end
      if (drop)                ovf_q    <= 1'b1;
    end
  end

  sync_fifo #(
    .pWidth (8),
    .pDepth (pFifoDepth)
  ) u_fifo (
    .clk_i   (iwClk),
    .rst_ni  (iwnRst),
    .push_i  (push),
    .data_i  (word.payload),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          cnt_d   = C_RELOAD;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = C_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = C_RELOAD;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more characters wait.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            cnt_d   = C_RELOAD;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iwClk) begin
    if (!iwnRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.owTx       = tx_q;
  assign bus.owHalt     = halt_q;
  assign bus.owExitCode = exit_q;
  assign bus.owOverflow = ovf_q;
  assign bus.owBusy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

`default_nettype wire
